// File: rtl/reg_write_queue.sv
// In-order register-write queue in front of the 16x32 register file: accepts up to two writes per cycle, retires one per cycle.
// Optional forwarding lookup over pending entries is enabled by defining FORWARD_EN.
module reg_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        wrA_valid,
  input  logic [3:0]  wrA_addr,
  input  logic [31:0] wrA_data,
  input  logic        wrB_valid,
  input  logic [3:0]  wrB_addr,
  input  logic [31:0] wrB_data,
  output logic        in_ready,
  output logic [3:0]  writeAddress,
  output logic [31:0] inputData,
  output logic        RW,
  output logic        pc_write,
  output logic        busy,
  input  logic [3:0]  fwdA_addr,
  input  logic [3:0]  fwdB_addr,
  output logic        fwdA_hit,
  output logic        fwdB_hit,
  output logic [31:0] fwdA_data,
  output logic [31:0] fwdB_data
);

  logic [PTRW:0]   count_q, count_d;
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [3:0]      addr_q [DEPTH];
  logic [3:0]      addr_d [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];

  logic            push_a, push_b, pop;
  logic [1:0]      n_push;
  logic [PTRW-1:0] idx_b;

  // Two free slots are always required so a dual push can never overflow.
  assign in_ready = (count_q <= (PTRW+1)'(DEPTH - 2));

  always_comb begin
    push_a = in_ready & wrA_valid;
    push_b = in_ready & wrB_valid;
    pop    = (count_q != '0);
    n_push = {1'b0, push_a} + {1'b0, push_b};
    idx_b  = push_a ? (tail_q + PTRW'(1)) : tail_q;
    addr_d = addr_q;
    data_d = data_q;
    if (push_a) begin
      addr_d[tail_q] = wrA_addr;
      data_d[tail_q] = wrA_data;
    end
    if (push_b) begin
      addr_d[idx_b] = wrB_addr;
      data_d[idx_b] = wrB_data;
    end
    count_d = count_q + (PTRW+1)'(n_push) - (PTRW+1)'(pop);
    head_d  = head_q + PTRW'(pop);
    tail_d  = tail_q + PTRW'(n_push);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage is not reset; only entries covered by count are meaningful.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    busy         = (count_q != '0);
    RW           = ~busy;
    writeAddress = busy ? addr_q[head_q] : 4'h0;
    inputData    = busy ? data_q[head_q] : 32'h0;
    pc_write     = busy && (addr_q[head_q] == 4'hF);
  end

`ifdef FORWARD_EN
  logic [PTRW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match is the newest pending value.
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdB_hit  = 1'b0;
    fwdA_data = 32'h0;
    fwdB_data = 32'h0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTRW'(i);
      if ((PTRW+1)'(i) < count_q) begin
        if (addr_q[fwd_idx] == fwdA_addr) begin
          fwdA_hit  = 1'b1;
          fwdA_data = data_q[fwd_idx];
        end
        if (addr_q[fwd_idx] == fwdB_addr) begin
          fwdB_hit  = 1'b1;
          fwdB_data = data_q[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_fwd_addr;

  assign unused_fwd_addr = ^{fwdA_addr, fwdB_addr};
  assign fwdA_hit  = 1'b0;
  assign fwdB_hit  = 1'b0;
  assign fwdA_data = 32'h0;
  assign fwdB_data = 32'h0;
`endif

endmodule
